demux_1to4: RTL and testbench
=============================

// Module: demux_1to4
// PURPOSE
//   1-to-4 demultiplexer with registered outputs. Routes data input i to one of
//   four outputs y0..y3, selected by {s1,s0}. Non-selected outputs are driven to 0.
//   Used as a generic fan-out/steering element on synchronous datapaths.
//   Outputs are registered: one clock, synchronous active-high reset.
// PARAMETERS
//   WIDTH  1  data width of i and of each of y0..y3 (must be >= 1)
// PORTS
//   clk  input   1      system clock; all state updates on rising edge
//   rst  input   1      synchronous reset, active-high
//   i    input   WIDTH  data input to be steered
//   s0   input   1      select bit 0 (LSB)
//   s1   input   1      select bit 1 (MSB)
//   y0   output  WIDTH  registered; = i when {s1,s0}=2'b00, else 0
//   y1   output  WIDTH  registered; = i when {s1,s0}=2'b01, else 0
//   y2   output  WIDTH  registered; = i when {s1,s0}=2'b10, else 0
//   y3   output  WIDTH  registered; = i when {s1,s0}=2'b11, else 0
// BEHAVIOUR
//   - Interface: one clock (clk); reset rst is synchronous and active-high.
//   - Reset: rst=1 sampled at a rising edge -> y0..y3 all 0 after that edge.
//     Reset has priority over the data path. All outputs are also 0 from
//     configuration until the first rising edge that samples rst=1.
//   - Select decode: sel = {s1,s0}; exactly one output lane is enabled per cycle.
//   - Latency: 1 cycle. Values of i/s0/s1 sampled at edge n appear on y* after
//     edge n and hold until edge n+1. No combinational path from inputs to outputs.
//   - Non-selected lanes: forced to all-zero WIDTH bits (not held, not high-Z).
//   - i=0 on the selected lane: all four outputs 0 (indistinguishable from idle).
//   - Select change: the previously selected lane drops to 0 and the new lane
//     takes i at the same edge; no cycle with two lanes non-zero, no gap cycle.
//   - X/Z on s0/s1: no requirement; the implementation must not latch.
//   - Reset mid-operation: outputs clear at the next edge; the cycle after
//     rst deasserts resumes normal steering with no warm-up.
//   - No internal state other than the four output registers.
// STRUCTURE
//   - Shared package demux_pkg: localparams SEL_Y0=2'b00, SEL_Y1=2'b01,
//     SEL_Y2=2'b10, SEL_Y3=2'b11; typedef sel_t = logic [1:0].
//   - Sub-module dec_2to4: combinational 2-to-4 one-hot decoder
//     (sel -> en[3:0]).
//   - Top: per-lane next value = en[k] ? i : '0, then a single always block
//     with synchronous reset.
// TESTING
//   1. rst=1 for 2 edges, i=1, sel=00 -> y0..y3 = 0,0,0,0.
//   2. rst=0, s1=0 s0=0 i=1 -> after next edge y0=1, y1=0, y2=0, y3=0.
//   3. Step sel through 01, 10, 11 (i=1), 10 time units apart ->
//      y1, then y2, then y3 one-hot, each 1 cycle after the sel change.
//   4. i=0 with every sel value -> all outputs 0.
//   5. WIDTH=8, sel=10, i=8'hA5 -> y2=8'hA5, others 8'h00.
//      Then rst=1 for one edge -> all 0; next edge y2=8'hA5 again.
//   6. Randomized i/sel for 1000 cycles vs reference model delayed 1 cycle
//      -> zero mismatches; one-hot/zero property holds on every cycle.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared select encodings and types for the 1-to-4 demultiplexer.
package demux_pkg;

    typedef logic [1:0] sel_t;

    localparam sel_t SEL_Y0 = 2'b00;
    localparam sel_t SEL_Y1 = 2'b01;
    localparam sel_t SEL_Y2 = 2'b10;
    localparam sel_t SEL_Y3 = 2'b11;

    localparam int unsigned NUM_LANES = 4;

endpackage

// File: rtl/demux_1to4_if.sv
// Data/select inputs and the four steered output lanes of demux_1to4.
interface demux_1to4_if #(
    parameter int unsigned WIDTH = 1
);

    logic [WIDTH-1:0] i;
    logic             s0;
    logic             s1;
    logic [WIDTH-1:0] y0;
    logic [WIDTH-1:0] y1;
    logic [WIDTH-1:0] y2;
    logic [WIDTH-1:0] y3;

    // Producer of data/select; consumer of the lanes.
    modport master (
        output i, s0, s1,
        input  y0, y1, y2, y3
    );

    // The demux itself.
    modport slave (
        input  i, s0, s1,
        output y0, y1, y2, y3
    );

endinterface

// File: rtl/dec_2to4.sv
// Combinational 2-to-4 one-hot decoder.
module dec_2to4
    import demux_pkg::*;
(
    input  sel_t       sel,
    output logic [3:0] en
);

    // One lane enable per select value; default keeps X selects latch-free.
    always_comb begin
        en = '0;
        case (sel)
            SEL_Y0:  en = 4'b0001;
            SEL_Y1:  en = 4'b0010;
            SEL_Y2:  en = 4'b0100;
            SEL_Y3:  en = 4'b1000;
            default: en = '0;
        endcase
    end

endmodule

// File: rtl/demux_1to4.sv
// 1-to-4 demultiplexer with registered outputs: i is steered to the lane
// chosen by {s1,s0}, every other lane is driven to zero, one cycle latency.
module demux_1to4
    import demux_pkg::*;
#(
    parameter int unsigned WIDTH = 1
) (
    input  logic         clk,
    input  logic         rst,
    demux_1to4_if.slave  bus
);

    sel_t                            sel;
    logic [NUM_LANES-1:0]            en;
    logic [NUM_LANES-1:0][WIDTH-1:0] y_d;
    // Zero initialiser so lanes read 0 from configuration until first reset.
    logic [NUM_LANES-1:0][WIDTH-1:0] y_q = '0;

    assign sel = {bus.s1, bus.s0};

    dec_2to4 u_dec (
        .sel (sel),
        .en  (en)
    );

    // Next value per lane: selected lane takes i, the others are forced to zero.
    always_comb begin
        y_d = '0;
        for (int k = 0; k < NUM_LANES; k++) begin
            y_d[k] = en[k] ? bus.i : '0;
        end
    end

    // Output registers; synchronous reset wins over the data path.
    always_ff @(posedge clk) begin
        if (rst) begin
            y_q <= '0;
        end else begin
            y_q <= y_d;
        end
    end

    assign bus.y0 = y_q[0];
    assign bus.y1 = y_q[1];
    assign bus.y2 = y_q[2];
    assign bus.y3 = y_q[3];

endmodule

// File: tb/tb_demux_1to4.sv
// Self-checking bench for demux_1to4: directed cases plus randomized traffic
// compared against a lane-array reference model.
module tb_demux_1to4;

    localparam int unsigned W = 8;

    logic clk;
    logic rst;

    demux_1to4_if #(.WIDTH(W)) dif ();

    demux_1to4 #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (dif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_tests;
    int unsigned n_fail;

    // Expected lane contents after the next edge / currently visible.
    logic [W-1:0] exp_lane [4];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, want);
        end
    endtask

    // Reference: lane number equals the select value; everything else is zero.
    task automatic model(input logic r, input logic [W-1:0] data, input int sel);
        for (int k = 0; k < 4; k++) begin
            exp_lane[k] = (!r && k == sel) ? data : '0;
        end
    endtask

    task automatic drive(input logic r, input logic [W-1:0] data, input int sel);
        rst    = r;
        dif.i  = data;
        dif.s0 = sel[0];
        dif.s1 = sel[1];
        model(r, data, sel);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_lanes(input string tag);
        logic [W-1:0] got [4];
        int nz;
        got[0] = dif.y0;
        got[1] = dif.y1;
        got[2] = dif.y2;
        got[3] = dif.y3;
        nz = 0;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("%s_y%0d", tag, k), 32'(got[k]), 32'(exp_lane[k]));
            if (got[k] != '0) nz++;
        end
        check({tag, "_onehot"}, 32'(nz <= 1), 32'd1);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;

        // Reset held for two edges.
        drive(1'b1, 8'h01, 0);
        tick();
        tick();
        check_lanes("reset");

        // Lane 0 after release.
        drive(1'b0, 8'h01, 0);
        tick();
        check_lanes("sel00");

        // Walk the select; each lane follows one cycle later, no overlap.
        for (int s = 1; s < 4; s++) begin
            drive(1'b0, 8'h01, s);
            tick();
            check_lanes($sformatf("walk%0d", s));
        end

        // Zero data on every select looks idle.
        for (int s = 0; s < 4; s++) begin
            drive(1'b0, 8'h00, s);
            tick();
            check_lanes($sformatf("zero%0d", s));
        end

        // Wide pattern, reset for one edge, then immediate resume.
        drive(1'b0, 8'hA5, 2);
        tick();
        check_lanes("a5");
        drive(1'b1, 8'hA5, 2);
        tick();
        check_lanes("a5_rst");
        drive(1'b0, 8'hA5, 2);
        tick();
        check_lanes("a5_resume");

        // Randomized traffic with occasional reset.
        for (int c = 0; c < 1000; c++) begin
            drive(($urandom_range(0, 19) == 0), W'($urandom), int'($urandom_range(0, 3)));
            tick();
            check_lanes($sformatf("rand%0d", c));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
